// File: rtl/matrix_scan_ctrl_if.sv
// matrix_scan_ctrl_if: control inputs and display/status outputs of the LED matrix scan controller
interface matrix_scan_ctrl_if;
    logic       en;
    logic [7:0] ch_raw;
    logic [7:0] spot_db;
    logic       sel;
    logic [1:0] col_n;
    logic [3:0] free_cnt;
    logic       full;
    logic       frame_tick;
    modport master (output en, ch_raw, input spot_db, sel, col_n, free_cnt, full, frame_tick);
    modport slave  (input en, ch_raw, output spot_db, sel, col_n, free_cnt, full, frame_tick);
endinterface

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: 2-column LED matrix scanner with blanking, spot switch debounce and free-spot count
module matrix_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int DEB_CYCLES   = 16
) (
    input logic               clk,
    input logic               rst,
    matrix_scan_ctrl_if.slave bus
);
    localparam int TMAX = SCAN_DIV > BLANK_CYCLES ? SCAN_DIV : BLANK_CYCLES;
    localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
    localparam int CW = $clog2(DEB_CYCLES) + 1;
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [TW-1:0] SCAN_LAST = TW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, C0_BLANK, C0_ON, C1_BLANK, C1_ON} state_t;
    state_t state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [7:0] db;
    logic [CW-1:0] cnt [8];
    logic [3:0] free_cnt;
    logic full;
    // scan state and shared phase timer
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
        end
    end
    // phase sequencing; en low forces IDLE ahead of any timer expiry
    always_comb begin
        state_nx = state;
        timer_nx = timer + 1'b1;
        if (!bus.en) begin
            state_nx = IDLE;
            timer_nx = '0;
        end else begin
            unique case (state)
                IDLE:     begin state_nx = C0_BLANK; timer_nx = '0; end
                C0_BLANK: if (timer == BLANK_LAST) begin state_nx = C0_ON; timer_nx = '0; end
                C0_ON:    if (timer == SCAN_LAST) begin state_nx = C1_BLANK; timer_nx = '0; end
                C1_BLANK: if (timer == BLANK_LAST) begin state_nx = C1_ON; timer_nx = '0; end
                C1_ON:    if (timer == SCAN_LAST) begin state_nx = C0_BLANK; timer_nx = '0; end
                default:  begin state_nx = IDLE; timer_nx = '0; end
            endcase
        end
    end
    assign bus.sel = state == C1_BLANK || state == C1_ON;
    assign bus.col_n = state == C0_ON ? 2'b10 : state == C1_ON ? 2'b01 : 2'b11;
    assign bus.frame_tick = state == C1_ON && timer == SCAN_LAST;
    // per-bit debounce: a bit flips only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            db <= '0;
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (bus.ch_raw[i] == db[i]) cnt[i] <= '0;
                else if (cnt[i] == DEB_LAST) begin
                    db[i] <= bus.ch_raw[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end
    // occupancy status, one cycle behind the debounced switches
    always_ff @(posedge clk) begin
        if (rst) begin
            free_cnt <= 4'd8;
            full <= 1'b0;
        end else begin
            free_cnt <= 4'(8 - $countones(db));
            full <= &db;
        end
    end
    assign bus.spot_db = db;
    assign bus.free_cnt = free_cnt;
    assign bus.full = full;
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb_matrix_scan_ctrl: directed checks of scan timing, debounce and occupancy status
module tb_matrix_scan_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic mon = 1'b0;
    logic psel = 1'b0;
    int total = 0;
    int bad = 0;
    matrix_scan_ctrl_if bus();
    matrix_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYCLES(1), .DEB_CYCLES(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // every cycle: never both columns lit, and sel only moves while dark
    always @(negedge clk) begin
        if (mon) begin
            chk("col_n_both_on", 8'(bus.col_n == 2'b00), 8'd0);
            if (bus.sel !== psel) chk("sel_move_dark", 8'(bus.col_n), 8'h3);
        end
        psel <= bus.sel;
    end
    initial begin
        logic [1:0] col_exp [13] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11,
                                     2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b10};
        bit found;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.ch_raw = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("t1_col_n", 8'(bus.col_n), 8'h3);
            chk("t1_sel", 8'(bus.sel), 8'h0);
            chk("t1_spot_db", bus.spot_db, 8'h00);
            chk("t1_free_cnt", 8'(bus.free_cnt), 8'd8);
            chk("t1_full", 8'(bus.full), 8'h0);
            chk("t1_frame_tick", 8'(bus.frame_tick), 8'h0);
            tick();
        end
        mon = 1'b1;
        bus.en = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            if (c <= 12) begin
                chk("t2_col_n", 8'(bus.col_n), 8'(col_exp[c]));
                chk("t2_sel", 8'(bus.sel), 8'(c >= 6 && c <= 10));
            end
            chk("t2_frame_tick", 8'(bus.frame_tick), 8'(c == 10 || c == 20 || c == 30));
            tick();
        end
        bus.ch_raw = 8'h01;
        tick();
        chk("t3_db_e1", bus.spot_db, 8'h00);
        tick();
        chk("t3_db_e2", bus.spot_db, 8'h00);
        tick();
        chk("t3_db_e3", bus.spot_db, 8'h01);
        chk("t3_free_lag", 8'(bus.free_cnt), 8'd8);
        tick();
        chk("t3_free_cnt", 8'(bus.free_cnt), 8'd7);
        bus.ch_raw = 8'h03;
        tick();
        tick();
        bus.ch_raw = 8'h01;
        for (int c = 0; c < 4; c++) tick();
        chk("t3_glitch_db", bus.spot_db, 8'h01);
        chk("t3_glitch_free", 8'(bus.free_cnt), 8'd7);
        bus.ch_raw = 8'hFF;
        tick();
        tick();
        chk("t4_db_e2", bus.spot_db, 8'h01);
        tick();
        chk("t4_db_e3", bus.spot_db, 8'hFF);
        chk("t4_full_lag", 8'(bus.full), 8'h0);
        tick();
        chk("t4_free_cnt", 8'(bus.free_cnt), 8'd0);
        chk("t4_full", 8'(bus.full), 8'h1);
        bus.ch_raw = 8'h7F;
        for (int c = 0; c < 4; c++) tick();
        chk("t4_db_7f", bus.spot_db, 8'h7F);
        chk("t4_free_1", 8'(bus.free_cnt), 8'd1);
        chk("t4_full_0", 8'(bus.full), 8'h0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (bus.col_n == 2'b01) found = 1'b1;
            else tick();
        end
        chk("t5_wait_c1_on", 8'(found), 8'h1);
        tick();
        bus.en = 1'b0;
        tick();
        chk("t5_off_col_n", 8'(bus.col_n), 8'h3);
        chk("t5_off_sel", 8'(bus.sel), 8'h0);
        tick();
        chk("t5_idle_col_n", 8'(bus.col_n), 8'h3);
        bus.en = 1'b1;
        tick();
        chk("t5_re_blank_col", 8'(bus.col_n), 8'h3);
        chk("t5_re_blank_sel", 8'(bus.sel), 8'h0);
        tick();
        chk("t5_re_c0_on", 8'(bus.col_n), 8'h2);
        bus.ch_raw = 8'h0F;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (bus.spot_db == 8'h0F && bus.col_n == 2'b10) found = 1'b1;
            else tick();
        end
        chk("t5_wait_0f_c0_on", 8'(found), 8'h1);
        rst = 1'b1;
        tick();
        chk("t5_rst_col_n", 8'(bus.col_n), 8'h3);
        chk("t5_rst_sel", 8'(bus.sel), 8'h0);
        chk("t5_rst_spot_db", bus.spot_db, 8'h00);
        chk("t5_rst_free", 8'(bus.free_cnt), 8'd8);
        chk("t5_rst_full", 8'(bus.full), 8'h0);
        chk("t5_rst_tick", 8'(bus.frame_tick), 8'h0);
        rst = 1'b0;
        bus.ch_raw = 8'h00;
        tick();
        chk("t5_after_rst_col", 8'(bus.col_n), 8'h3);
        tick();
        chk("t5_restart_c0_on", 8'(bus.col_n), 8'h2);
        mon = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
